// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator: ROM address generation, prefetch FIFO, redirect/flush, fault halt.
// Optional fetch statistics counters are compiled in with `define FETCH_STAT_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        rom_accessable,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_STAT_EN
  output logic [31:0] stat_fetched,
  output logic [15:0] stat_faults,
`endif
  output logic        fetch_halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {FETCH, HALT} state_t;

  state_t                   state_q, state_d;
  logic [31:0]              fetch_pc_q, fetch_pc_d;
  logic [DEPTH-1:0][31:0]   pc_q, data_q;
  logic [DEPTH-1:0]         fault_q;
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     push, pop, push_fault;

  assign inst_valid   = (cnt_q != '0);
  assign pop          = inst_valid && inst_ready && !redirect_valid;
  assign push         = (state_q == FETCH) && !redirect_valid &&
                        ((cnt_q < CW'(DEPTH)) || pop);
  assign push_fault   = push && !rom_accessable;

  assign rom_addr     = fetch_pc_q;
  assign inst         = data_q[rd_ptr_q];
  assign inst_pc      = pc_q[rd_ptr_q];
  assign inst_fault   = fault_q[rd_ptr_q];
  assign fetch_halted = (state_q == HALT);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    cnt_d      = cnt_q;
    if (redirect_valid) begin
      state_d    = FETCH;
      fetch_pc_d = redirect_pc;
      cnt_d      = '0;
    end else begin
      if (push_fault)
        state_d = HALT;
      else if (push)
        fetch_pc_d = fetch_pc_q + 32'd4;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  // Pointers return to 0 on flush so the head slot is deterministic after redirect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= '0;
      data_q   <= '0;
      fault_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (redirect_valid) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr_q]    <= fetch_pc_q;
        data_q[wr_ptr_q]  <= rom_data;
        fault_q[wr_ptr_q] <= !rom_accessable;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

`ifdef FETCH_STAT_EN
  logic [31:0] stat_fetched_q;
  logic [15:0] stat_faults_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetched_q <= '0;
      stat_faults_q  <= '0;
    end else if (push_fault) begin
      stat_faults_q  <= stat_faults_q + 16'd1;
    end else if (push) begin
      stat_fetched_q <= stat_fetched_q + 32'd1;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_faults  = stat_faults_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: boot, backpressure, redirect, fault halt, async reset.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rom_addr, rom_data, inst, inst_pc, redirect_pc;
  logic        rom_accessable, inst_fault, inst_valid, inst_ready, redirect_valid, fetch_halted;
`ifdef FETCH_STAT_EN
  logic [31:0] stat_fetched;
  logic [15:0] stat_faults;
`endif

  inst_fetch_unit #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .rom_addr(rom_addr), .rom_data(rom_data), .rom_accessable(rom_accessable),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_STAT_EN
    .stat_fetched(stat_fetched), .stat_faults(stat_faults),
`endif
    .fetch_halted(fetch_halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } ent_t;

  ent_t sb[$];
  ent_t got, exp_e;
  int   checks = 0;
  int   passed = 0;

  function automatic logic rom_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) &&
           ((a <= 32'h8) || (a >= 32'h00400000 && a < 32'h00400100));
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (!rom_ok(a)) return 32'h0;
    case (a)
      32'h0:   return 32'h3c110040;
      32'h4:   return 32'h26310000;
      32'h8:   return 32'h02200008;
      default: return 32'hA5000000 ^ a;
    endcase
  endfunction

  always_comb begin
    rom_accessable = rom_ok(rom_addr);
    rom_data       = rom_word(rom_addr);
  end

  function automatic ent_t mk(input logic [31:0] pc, input logic flt);
    ent_t e;
    e.pc    = pc;
    e.data  = flt ? 32'h0 : rom_word(pc);
    e.fault = flt;
    return e;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
    checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", inst_valid); else passed++;
    checks++; if (inst !== 32'h0) $display("FAIL rst_inst got %h exp 0", inst); else passed++;
    checks++; if (inst_pc !== 32'h0) $display("FAIL rst_pc got %h exp 0", inst_pc); else passed++;
    checks++; if (inst_fault !== 1'b0) $display("FAIL rst_fault got %b exp 0", inst_fault); else passed++;
    checks++; if (fetch_halted !== 1'b0) $display("FAIL rst_halt got %b exp 0", fetch_halted); else passed++;
    checks++; if (rom_addr !== 32'h0) $display("FAIL rst_addr got %h exp 0", rom_addr); else passed++;
  endtask

  task automatic test_boot();
    int k, lastc;
    k = 0; lastc = -1;
    @(negedge clk); reset = 1'b0; inst_ready = 1'b1;
    sb.delete();
    sb.push_back(mk(32'h0, 1'b0)); sb.push_back(mk(32'h4, 1'b0));
    sb.push_back(mk(32'h8, 1'b0)); sb.push_back(mk(32'hC, 1'b1));
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready && !redirect_valid) begin
        got = {inst_pc, inst, inst_fault}; exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) $display("FAIL boot_entry got %h exp %h", got, exp_e); else passed++;
        checks++;
        if (c !== k) $display("FAIL boot_cycle got %0d exp %0d", c, k); else passed++;
        k++; lastc = c;
      end
    end
    if (sb.size() != 0) begin checks++; $display("FAIL boot_timeout left %0d exp 0", sb.size()); sb.delete(); end
    repeat (2) @(negedge clk);
    checks++; if (fetch_halted !== 1'b1) $display("FAIL boot_halt got %b exp 1", fetch_halted); else passed++;
    checks++; if (rom_addr !== 32'hC) $display("FAIL boot_haltaddr got %h exp c", rom_addr); else passed++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL boot_empty got %b exp 0", inst_valid); else passed++;
`ifdef FETCH_STAT_EN
    checks++; if (stat_fetched !== 32'd3) $display("FAIL stat_fetched got %0d exp 3", stat_fetched); else passed++;
    checks++; if (stat_faults !== 16'd1) $display("FAIL stat_faults got %0d exp 1", stat_faults); else passed++;
`endif
  endtask

  task automatic test_backpressure();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; inst_ready = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (inst_valid !== 1'b1) $display("FAIL bp_valid got %b exp 1", inst_valid); else passed++;
    checks++; if (inst_pc !== 32'h0) $display("FAIL bp_hold_pc got %h exp 0", inst_pc); else passed++;
    checks++; if (rom_addr !== 32'h8) $display("FAIL bp_stall_addr got %h exp 8", rom_addr); else passed++;
    sb.delete();
    sb.push_back(mk(32'h0, 1'b0)); sb.push_back(mk(32'h4, 1'b0)); sb.push_back(mk(32'h8, 1'b0));
    inst_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      if (c != 0) @(negedge clk);
      if (inst_valid && inst_ready && !redirect_valid) begin
        got = {inst_pc, inst, inst_fault}; exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) $display("FAIL bp_entry got %h exp %h", got, exp_e); else passed++;
      end
    end
    if (sb.size() != 0) begin checks++; $display("FAIL bp_timeout left %0d exp 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_redirect_full();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h00400000; inst_ready = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0) $display("FAIL rd_flush got %b exp 0", inst_valid); else passed++;
    redirect_valid = 1'b0;
    sb.push_back(mk(32'h00400000, 1'b0)); sb.push_back(mk(32'h00400004, 1'b0));
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready && !redirect_valid) begin
        got = {inst_pc, inst, inst_fault}; exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) $display("FAIL rd_entry got %h exp %h", got, exp_e); else passed++;
      end
    end
    if (sb.size() != 0) begin checks++; $display("FAIL rd_timeout left %0d exp 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h00400002; inst_ready = 1'b1;
    sb.delete();
    @(negedge clk); redirect_valid = 1'b0;
    sb.push_back(mk(32'h00400002, 1'b1));
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready && !redirect_valid) begin
        got = {inst_pc, inst, inst_fault}; exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) $display("FAIL mis_entry got %h exp %h", got, exp_e); else passed++;
      end
    end
    if (sb.size() != 0) begin checks++; $display("FAIL mis_timeout left %0d exp 0", sb.size()); sb.delete(); end
    repeat (2) @(negedge clk);
    checks++; if (inst_valid !== 1'b0) $display("FAIL mis_single got %b exp 0", inst_valid); else passed++;
    checks++; if (fetch_halted !== 1'b1) $display("FAIL mis_halt got %b exp 1", fetch_halted); else passed++;
    checks++; if (rom_addr !== 32'h00400002) $display("FAIL mis_addr got %h exp 00400002", rom_addr); else passed++;
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    @(negedge clk); redirect_valid = 1'b0;
    checks++; if (fetch_halted !== 1'b0) $display("FAIL mis_resume got %b exp 0", fetch_halted); else passed++;
    sb.push_back(mk(32'h0, 1'b0)); sb.push_back(mk(32'h4, 1'b0));
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready && !redirect_valid) begin
        got = {inst_pc, inst, inst_fault}; exp_e = sb.pop_front(); checks++;
        if (got !== exp_e) $display("FAIL resume_entry got %h exp %h", got, exp_e); else passed++;
      end
    end
    if (sb.size() != 0) begin checks++; $display("FAIL resume_timeout left %0d exp 0", sb.size()); sb.delete(); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; inst_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (inst_valid !== 1'b1) $display("FAIL ar_pre_valid got %b exp 1", inst_valid); else passed++;
    checks++; if (rom_addr !== 32'h8) $display("FAIL ar_pre_addr got %h exp 8", rom_addr); else passed++;
    #2 reset = 1'b1;
    #1;
    checks++; if (inst_valid !== 1'b0) $display("FAIL ar_valid got %b exp 0", inst_valid); else passed++;
    checks++; if (rom_addr !== 32'h0) $display("FAIL ar_addr got %h exp 0", rom_addr); else passed++;
`ifdef FETCH_STAT_EN
    checks++; if (stat_fetched !== 32'd0) $display("FAIL ar_stat_fetched got %0d exp 0", stat_fetched); else passed++;
    checks++; if (stat_faults !== 16'd0) $display("FAIL ar_stat_faults got %0d exp 0", stat_faults); else passed++;
`endif
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect_full();
    test_misaligned();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch initiator for the boot/instruction ROM.
- Drives the ROM address and samples the ROM's combinational data/accessable response in the same cycle.
- Buffers fetched words in a small prefetch FIFO and presents them to the CPU core through a valid/ready handshake.
- Supports redirect (jump/branch/exception) with flush, and flags inaccessible fetches as faults.

Parameters:
- RESET_PC, 32'h00000000, fetch address loaded on reset (boot region).
- DEPTH, 2, prefetch FIFO entries (power of two, 2..8).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rom_addr  output  32  fetch address to ROM, equal to fetch_pc.
- rom_data  input  32  ROM read data, combinational from rom_addr.
- rom_accessable  input  1  ROM hit flag; 0 means unmapped or misaligned address.
- inst  output  32  head-of-FIFO instruction word.
- inst_pc  output  32  address of head instruction.
- inst_fault  output  1  head entry came from an inaccessible fetch.
- inst_valid  output  1  FIFO non-empty.
- inst_ready  input  1  core accepts head this cycle.
- redirect_valid  input  1  load new fetch address and flush.
- redirect_pc  input  32  new fetch address.
- fetch_halted  output  1  fetching stopped after a fault.

Behaviour:
- Reset (async, active-high):
  - fetch_pc=RESET_PC; FIFO count=0; all entry storage zeroed; state=FETCH.
  - Outputs: inst_valid=0, inst=0, inst_pc=0, inst_fault=0, fetch_halted=0.
  - rom_addr=RESET_PC.
- States:
  - FETCH: normal fetching.
  - HALT: entered on a fault push; fetch_halted=1; rom_addr holds the faulting address; no pushes.
  - HALT is left only by redirect or reset.
- Pop: occurs when inst_valid && inst_ready && !redirect_valid.
- Push: occurs in FETCH when !redirect_valid && (count<DEPTH || pop).
  - Entry written: {pc=fetch_pc, data=rom_data, fault=!rom_accessable}.
  - fetch_pc <= fetch_pc+4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
  - If the fault bit is set: state<=HALT and fetch_pc is not incremented.
- Simultaneous push and pop, including when full: count unchanged and ordering preserved.
- Redirect has priority over everything:
  - FIFO count<=0; any same-cycle pop or push is discarded.
  - fetch_pc<=redirect_pc; state<=FETCH.
  - inst_valid=0 in the following cycle.
- Latency:
  - Word fetched in cycle N is visible at inst in cycle N+1.
  - Sustained throughput is 1 instruction/cycle with inst_ready held high.
- Outputs inst/inst_pc/inst_fault are valid only while inst_valid=1; they hold their value while inst_valid && !inst_ready.
- Misaligned redirect_pc: no special handling; the ROM reports inaccessible, which produces a fault entry.
- Fault entry: inst=rom_data as driven (ROM supplies 0); the core must trap on inst_fault.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); a partial push is discarded.
- FIFO pointers wrap modulo DEPTH; count is held in a separate register of width clog2(DEPTH)+1.

Optional Feature:
- Macro: FETCH_STAT_EN.
- When defined, adds two outputs, reset to 0:
  - stat_fetched, 32 bits: increments on every non-fault push.
  - stat_faults, 16 bits: increments on every fault push.
  - Both wrap on overflow and are not cleared by redirect.
- When undefined, neither port nor the counter logic exists.

Test Plan:
- Boot fetch, ROM boot region mapped 0x0..0x8, inst_ready=1:
  - After reset release, expect inst/pc pairs 32'h3c110040@0x0, 32'h26310000@0x4, 32'h02200008@0x8 on consecutive cycles.
  - Then expect a fault entry @0xC, then fetch_halted=1 with rom_addr held at 0xC.
- Backpressure:
  - inst_ready=0 for 5 cycles after reset: inst_valid=1, inst_pc held 0x0, rom_addr stalls at 0x8 with count=2.
  - Raise inst_ready: 0x0, 0x4, 0x8 delivered in order with no loss or duplication.
- Redirect while full: redirect_valid=1, redirect_pc=32'h00400000 with inst_ready=1 in the same cycle:
  - No pop counted; inst_valid=0 the next cycle.
  - Following entry inst_pc=32'h00400000 with the ROM word at that address.
- Misaligned redirect to 32'h00400002 (ROM accessable=0):
  - Single entry with inst_fault=1, inst_pc=32'h00400002; fetch_halted=1.
  - Redirect to 0x0 clears the halt and resumes fetching at 0x0.
- Async reset asserted mid-stream with the FIFO holding 2 entries:
  - inst_valid=0 immediately, without waiting for a clock edge.
  - rom_addr=RESET_PC; stats (FETCH_STAT_EN) read 0.
- FETCH_STAT_EN, boot scenario 1 run to halt: stat_fetched=3, stat_faults=1.
